// File: rtl/program_loader.sv
// Byte-stream program loader: fills instruction memory with a
// length-prefixed halfword image and holds the core in reset until done.
module program_loader #(
  parameter int ADDR_W = 9
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        program_mem_write_en_o,
  output logic [15:0] instruction_o,
  output logic [31:0] instruction_addr_o,
  output logic        cpu_reset_o,
  output logic        load_done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] LEN_MAX = 17'(1) << ADDR_W;

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        len_lo_q;
  logic [7:0]        data_lo_q;
  logic [7:0]        data_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic              ready_q;
  logic              we_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;
  logic              xfer;
  logic [15:0]       len_n;
  logic              len_bad;

  assign xfer    = byte_valid_i & ready_q;
  assign len_n   = {byte_i, len_lo_q};
  assign len_bad = (len_n == 16'd0) || ({1'b0, len_n} > LEN_MAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERROR: if (start_i) state_d = LEN_LO;
      LEN_LO:  if (xfer) state_d = LEN_HI;
      LEN_HI:  if (xfer) state_d = len_bad ? ERROR : DATA_LO;
      DATA_LO: if (xfer) state_d = DATA_HI;
      DATA_HI: if (xfer) state_d = WRITE;
      WRITE:   state_d = (rem_q == (ADDR_W+1)'(1)) ? DONE : DATA_LO;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      len_lo_q  <= '0;
      data_lo_q <= '0;
      data_hi_q <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == LEN_LO) || (state_d == LEN_HI) ||
                   (state_d == DATA_LO) || (state_d == DATA_HI);
      we_q      <= (state_d == WRITE);
      cpu_rst_q <= (state_d != DONE);
      done_q    <= (state_d == DONE);
      err_q     <= (state_d == ERROR);
      unique case (state_q)
        IDLE, DONE, ERROR: if (start_i) addr_q <= '0;
        LEN_LO:  if (xfer) len_lo_q <= byte_i;
        LEN_HI:  if (xfer) rem_q <= len_n[ADDR_W:0];
        DATA_LO: if (xfer) data_lo_q <= byte_i;
        DATA_HI: if (xfer) data_hi_q <= byte_i;
        WRITE: begin
          rem_q <= rem_q - 1'b1;
          // hold the final address so it never wraps past the top
          if (rem_q != (ADDR_W+1)'(1)) addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign byte_ready_o           = ready_q;
  assign program_mem_write_en_o = we_q;
  assign instruction_o          = {data_hi_q, data_lo_q};
  assign instruction_addr_o     = {{(32-ADDR_W){1'b0}}, addr_q};
  assign cpu_reset_o            = cpu_rst_q;
  assign load_done_o            = done_q;
  assign error_o                = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as
// bytes are streamed and retired by a strobe monitor.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        bvalid = 1'b0;
  logic [7:0]  bdata = 8'h00;
  logic        bready;
  logic        we;
  logic [15:0] instr;
  logic [31:0] iaddr;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [47:0] sb[$];

  program_loader #(.ADDR_W(9)) dut (
    .clk_i                  (clk),
    .reset_n_i              (reset_n),
    .start_i                (start),
    .byte_valid_i           (bvalid),
    .byte_i                 (bdata),
    .byte_ready_o           (bready),
    .program_mem_write_en_o (we),
    .instruction_o          (instr),
    .instruction_addr_o     (iaddr),
    .cpu_reset_o            (cpu_rst),
    .load_done_o            (done),
    .error_o                (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && we) begin
      if (sb.size() == 0) chk("extra_write", {iaddr, instr}, '1);
      else chk("write", {iaddr, instr}, sb.pop_front());
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    bvalid = 1'b1;
    bdata  = b;
    @(negedge clk);
    while (!bready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 48'(n), 48'd0);
    @(posedge clk);
    #1;
    if (gap) begin
      bvalid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_valid();
    bvalid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 48'(done), 48'd1);
  endtask

  initial begin
    #12;
    chk("rst_ready", 48'(bready), 48'd0);
    chk("rst_we", 48'(we), 48'd0);
    chk("rst_instr", 48'(instr), 48'd0);
    chk("rst_addr", 48'(iaddr), 48'd0);
    chk("rst_cpu", 48'(cpu_rst), 48'd1);
    chk("rst_done", 48'(done), 48'd0);
    chk("rst_err", 48'(err), 48'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back two-word image
    pulse_start();
    sb.push_back({32'd0, 16'h1234});
    sb.push_back({32'd1, 16'h5678});
    send(8'h02, 0); send(8'h00, 0);
    send(8'h34, 0); send(8'h12, 0);
    send(8'h78, 0); send(8'h56, 0);
    idle_valid();
    wait_done(20);
    chk("b2b_cpu_rst", 48'(cpu_rst), 48'd0);
    chk("b2b_sb_empty", 48'(sb.size()), 48'd0);

    // reload from DONE
    pulse_start();
    chk("reload_cpu_rst", 48'(cpu_rst), 48'd1);
    chk("reload_done", 48'(done), 48'd0);
    chk("reload_ready", 48'(bready), 48'd1);

    // gapped stream with start held high through the data phase
    start = 1'b1;
    sb.push_back({32'd0, 16'h1234});
    sb.push_back({32'd1, 16'h5678});
    send(8'h02, 1); send(8'h00, 1);
    send(8'h34, 1); send(8'h12, 1);
    send(8'h78, 1);
    start = 1'b0;
    send(8'h56, 1);
    wait_done(20);
    chk("gap_sb_empty", 48'(sb.size()), 48'd0);

    // zero length
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    idle_valid();
    chk("len0_err", 48'(err), 48'd1);
    chk("len0_ready", 48'(bready), 48'd0);
    chk("len0_cpu", 48'(cpu_rst), 48'd1);
    pulse_start();
    chk("err_clear", 48'(err), 48'd0);
    chk("err_relen", 48'(bready), 48'd1);

    // one past capacity
    send(8'h01, 0); send(8'h02, 0);
    idle_valid();
    chk("len513_err", 48'(err), 48'd1);

    // full capacity image
    pulse_start();
    send(8'h00, 0); send(8'h02, 0);
    for (int i = 0; i < 512; i++) begin
      logic [15:0] w;
      w = 16'(i * 16'h0135) ^ 16'hA5C3;
      sb.push_back({32'(i), w});
      send(w[7:0], 0);
      send(w[15:8], 0);
    end
    idle_valid();
    wait_done(20);
    chk("full_sb_empty", 48'(sb.size()), 48'd0);
    chk("full_last_addr", 48'(iaddr), 48'd511);

    // async reset landing in WRITE
    pulse_start();
    send(8'h01, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0);
    idle_valid();
    chk("pre_rst_we", 48'(we), 48'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_we", 48'(we), 48'd0);
    chk("arst_cpu", 48'(cpu_rst), 48'd1);
    chk("arst_ready", 48'(bready), 48'd0);
    chk("arst_addr", 48'(iaddr), 48'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_done", 48'(done), 48'd0);
    chk("post_sb_empty", 48'(sb.size()), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
